// File: rtl/fft_pkg.sv
// Shared definitions for the FFT datapath: rounding-mode constants and a
// generic signed saturation helper.
package fft_pkg;

    localparam int RND_TRUNC   = 0;
    localparam int RND_HALF_UP = 1;

    localparam int SAT_MAX_W = 64;

    typedef struct packed {
        logic signed [SAT_MAX_W-1:0] value;
        logic                        sat;
    } sat_res_t;

    // Clamp a sign-extended value into the signed range of a w-bit word.
    function automatic sat_res_t sat_w(input logic signed [SAT_MAX_W-1:0] x,
                                       input int w);
        logic signed [SAT_MAX_W-1:0] hi;
        logic signed [SAT_MAX_W-1:0] lo;
        sat_res_t r;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi) begin
            r.value = hi;
            r.sat   = 1'b1;
        end else if (x < lo) begin
            r.value = lo;
            r.sat   = 1'b1;
        end else begin
            r.value = x;
            r.sat   = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/cmult_pipe_round_sat.sv
// Combinational round / arithmetic shift / saturate for one component of a
// wide product sum, back to the signed W-bit sample format.
module round_sat
    import fft_pkg::*;
#(
    parameter int W    = 16,
    parameter int F    = 14,
    parameter int RND  = RND_HALF_UP,
    parameter int IN_W = 33
) (
    input  logic signed [IN_W-1:0] din,
    output logic signed [W-1:0]    dout,
    output logic                   sat
);

    localparam logic signed [IN_W:0] BIAS =
        (RND == RND_HALF_UP) ? (IN_W+1)'(2 ** (F - 1)) : '0;

    logic signed [IN_W:0] biased;
    logic signed [IN_W:0] shifted;
    sat_res_t             res;
    logic                 unused_hi;

    // One extra bit keeps the rounding bias from wrapping at the top of the range.
    always_comb begin
        biased  = (IN_W+1)'(din) + BIAS;
        shifted = biased >>> F;
        res     = sat_w(SAT_MAX_W'(shifted), W);
        dout    = res.value[W-1:0];
        sat     = res.sat;
    end

    assign unused_hi = ^res.value[SAT_MAX_W-1:W];

endmodule

// File: rtl/cmult_pipe.sv
// Three-stage signed complex multiplier (optionally by the conjugate) with a
// single stall-everything valid/ready handshake and a tag sideband.
module cmult_pipe
    import fft_pkg::*;
#(
    parameter  int I     = 2,
    parameter  int F     = 14,
    parameter  int RND   = RND_HALF_UP,
    parameter  int TAG_W = 8,
    localparam int W     = I + F
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    output logic                 i_ready,
    input  logic                 i_conj,
    input  logic signed [W-1:0]  i_data1_re,
    input  logic signed [W-1:0]  i_data1_im,
    input  logic signed [W-1:0]  i_data2_re,
    input  logic signed [W-1:0]  i_data2_im,
    input  logic [TAG_W-1:0]     i_tag,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic signed [W-1:0]  o_data_re,
    output logic signed [W-1:0]  o_data_im,
    output logic                 o_sat,
    output logic [TAG_W-1:0]     o_tag
);

    localparam int PW = 2 * W;
    localparam int SW = 2 * W + 1;

    logic adv;

    logic                 vld_p1;
    logic signed [PW-1:0] ac_p1;
    logic signed [PW-1:0] ad_p1;
    logic signed [PW-1:0] bc_p1;
    logic signed [PW-1:0] bd_p1;
    logic                 conj_p1;
    logic [TAG_W-1:0]     tag_p1;

    logic                 vld_p2;
    logic signed [SW-1:0] re_p2;
    logic signed [SW-1:0] im_p2;
    logic [TAG_W-1:0]     tag_p2;

    logic signed [W-1:0]  re_rs;
    logic signed [W-1:0]  im_rs;
    logic                 re_sat;
    logic                 im_sat;

    // The whole pipe moves as one unit; a held output freezes every stage.
    assign adv     = !o_valid || o_ready;
    assign i_ready = adv;

    // ---- stage 1: partial products ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1 <= 1'b0;
        end else if (adv) begin
            vld_p1 <= i_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (adv && i_valid) begin
            ac_p1   <= PW'(i_data1_re) * PW'(i_data2_re);
            ad_p1   <= PW'(i_data1_re) * PW'(i_data2_im);
            bc_p1   <= PW'(i_data1_im) * PW'(i_data2_re);
            bd_p1   <= PW'(i_data1_im) * PW'(i_data2_im);
            conj_p1 <= i_conj;
            tag_p1  <= i_tag;
        end
    end

    // ---- stage 2: full-precision sums ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p2 <= 1'b0;
        end else if (adv) begin
            vld_p2 <= vld_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (adv && vld_p1) begin
            if (conj_p1) begin
                re_p2 <= SW'(ac_p1) + SW'(bd_p1);
                im_p2 <= SW'(bc_p1) - SW'(ad_p1);
            end else begin
                re_p2 <= SW'(ac_p1) - SW'(bd_p1);
                im_p2 <= SW'(ad_p1) + SW'(bc_p1);
            end
            tag_p2 <= tag_p1;
        end
    end

    // ---- stage 3: round, saturate, output register ----
    round_sat #(.W(W), .F(F), .RND(RND), .IN_W(SW)) u_rs_re (
        .din  (re_p2),
        .dout (re_rs),
        .sat  (re_sat)
    );

    round_sat #(.W(W), .F(F), .RND(RND), .IN_W(SW)) u_rs_im (
        .din  (im_p2),
        .dout (im_rs),
        .sat  (im_sat)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_valid   <= 1'b0;
            o_data_re <= '0;
            o_data_im <= '0;
            o_sat     <= 1'b0;
            o_tag     <= '0;
        end else if (adv) begin
            o_valid <= vld_p2;
            if (vld_p2) begin
                o_data_re <= re_rs;
                o_data_im <= im_rs;
                o_sat     <= re_sat || im_sat;
                o_tag     <= tag_p2;
            end
        end
    end

endmodule

// File: tb/tb_cmult_pipe.sv
// Bench for cmult_pipe: directed corner cases, backpressure, async reset and a
// random stream scored against an integer-arithmetic reference model.
module tb_cmult_pipe;

    localparam int W     = 16;
    localparam int F     = 14;
    localparam int TAG_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic i_valid = 1'b0;
    logic i_conj = 1'b0;
    logic signed [W-1:0] a = '0, b = '0, c = '0, d = '0;
    logic [TAG_W-1:0] i_tag = '0;
    logic o_ready = 1'b1;

    logic i_ready, o_valid, o_sat;
    logic signed [W-1:0] o_data_re, o_data_im;
    logic [TAG_W-1:0] o_tag;

    logic t_i_ready, t_o_valid, t_o_sat;
    logic signed [W-1:0] t_o_data_re, t_o_data_im;
    logic [TAG_W-1:0] t_o_tag;

    typedef struct {
        logic signed [W-1:0] re, im, re_t;
        logic                sat;
        logic [TAG_W-1:0]    tag;
    } exp_t;

    exp_t             sb[$];
    logic [TAG_W-1:0] seen[$];
    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    cmult_pipe #(.I(2), .F(F), .RND(1), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready), .i_conj(i_conj),
        .i_data1_re(a), .i_data1_im(b), .i_data2_re(c), .i_data2_im(d), .i_tag(i_tag),
        .o_valid(o_valid), .o_ready(o_ready), .o_data_re(o_data_re),
        .o_data_im(o_data_im), .o_sat(o_sat), .o_tag(o_tag)
    );

    cmult_pipe #(.I(2), .F(F), .RND(0), .TAG_W(TAG_W)) dut_trunc (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(t_i_ready), .i_conj(i_conj),
        .i_data1_re(a), .i_data1_im(b), .i_data2_re(c), .i_data2_im(d), .i_tag(i_tag),
        .o_valid(t_o_valid), .o_ready(o_ready), .o_data_re(t_o_data_re),
        .o_data_im(t_o_data_im), .o_sat(t_o_sat), .o_tag(t_o_tag)
    );

    task automatic check(input string name, input logic signed [63:0] obs,
                         input logic signed [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", name, obs, expv);
        end
    endtask

    // Reference: exact integer product sum, floor division by 2^F, clamp.
    function automatic void fit(input longint v, output logic signed [W-1:0] q,
                                output logic s);
        if (v > 32767) begin q = 16'sd32767; s = 1'b1; end
        else if (v < -32768) begin q = -16'sd32768; s = 1'b1; end
        else begin q = 16'(v); s = 1'b0; end
    endfunction

    function automatic exp_t model(input longint ar, ai, br, bi, input bit cj,
                                   input logic [TAG_W-1:0] tg);
        longint pr, pi;
        logic s1, s2, s3;
        exp_t e;
        pr = cj ? ar * br + ai * bi : ar * br - ai * bi;
        pi = cj ? ai * br - ar * bi : ar * bi + ai * br;
        fit((pr + 8192) >>> F, e.re, s1);
        fit((pi + 8192) >>> F, e.im, s2);
        fit(pr >>> F, e.re_t, s3);
        e.sat = s1 | s2;
        e.tag = tg;
        return e;
    endfunction

    task automatic tick();
        bit in_x, out_x, stalled;
        exp_t e;
        logic signed [W-1:0] s_re, s_im, s_tre;
        logic s_sat, s_tv;
        logic [TAG_W-1:0] s_tag;
        @(negedge clk);
        in_x    = i_valid && i_ready;
        out_x   = o_valid && o_ready;
        stalled = o_valid && !o_ready;
        s_re = o_data_re; s_im = o_data_im; s_sat = o_sat; s_tag = o_tag;
        s_tre = t_o_data_re; s_tv = t_o_valid;
        if (in_x) sb.push_back(model(a, b, c, d, i_conj, i_tag));
        @(posedge clk);
        #1;
        cyc++;
        if (out_x) begin
            seen.push_back(s_tag);
            if (sb.size() == 0) begin
                check("unexpected_output", longint'(sb.size()), 1);
            end else begin
                e = sb.pop_front();
                check("sb_re", s_re, e.re);
                check("sb_im", s_im, e.im);
                check("sb_sat", s_sat, e.sat);
                check("sb_tag", s_tag, e.tag);
                check("sb_trunc_valid", s_tv, 1);
                check("sb_trunc_re", s_tre, e.re_t);
            end
        end
        if (stalled) begin
            check("hold_re", o_data_re, s_re);
            check("hold_im", o_data_im, s_im);
            check("hold_sat", o_sat, s_sat);
            check("hold_tag", o_tag, s_tag);
        end
    endtask

    task automatic drive(input logic signed [W-1:0] va, vb, vc, vd, input bit cj,
                         input logic [TAG_W-1:0] tg, input bit v);
        a = va; b = vb; c = vc; d = vd; i_conj = cj; i_tag = tg; i_valid = v;
    endtask

    task automatic directed(input string nm, input logic signed [W-1:0] va, vb, vc, vd,
                            input bit cj, input logic [TAG_W-1:0] tg,
                            input longint ere, eim, input bit esat, input longint etre);
        drive(va, vb, vc, vd, cj, tg, 1'b1);
        tick();
        i_valid = 1'b0;
        tick();
        tick();
        check({nm, "_valid"}, o_valid, 1);
        check({nm, "_re"}, o_data_re, ere);
        check({nm, "_im"}, o_data_im, eim);
        check({nm, "_sat"}, o_sat, esat);
        check({nm, "_tag"}, o_tag, tg);
        check({nm, "_trunc_re"}, t_o_data_re, etre);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, rel, c0;
        #3;
        check("rst_o_valid", o_valid, 0);
        check("rst_o_data_re", o_data_re, 0);
        check("rst_o_tag", o_tag, 0);
        #14 rst = 1'b1;
        tick();
        check("rst_i_ready", i_ready, 1);

        // 0.5 * 0.5 style operands and the clamp / rounding corners
        directed("basic", 16'sd8192, 16'sd8192, 16'sd8192, -16'sd8192, 1'b0, 8'h11,
                 8192, 0, 1'b0, 8192);
        directed("conj", 16'sd8192, 16'sd8192, 16'sd8192, -16'sd8192, 1'b1, 8'h12,
                 0, 8192, 1'b0, 0);
        directed("sat_pos", -16'sd32768, 16'sd0, -16'sd32768, 16'sd0, 1'b0, 8'h13,
                 32767, 0, 1'b1, 32767);
        directed("sat_neg", -16'sd32768, 16'sd0, -16'sd32768, 16'sd32767, 1'b0, 8'h14,
                 32767, -32768, 1'b1, 32767);
        directed("round", 16'sd1, 16'sd0, 16'sd8192, 16'sd0, 1'b0, 8'h5A,
                 1, 0, 1'b0, 0);
        tick();

        // Backpressure: 10 tagged samples, o_ready low for cycles 5..9
        seen.delete();
        n = 0;
        for (rel = 0; rel < 40 && !(n == 10 && sb.size() == 0); rel++) begin
            o_ready = !(rel >= 5 && rel < 10);
            drive(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                  1'($urandom), 8'(n), n < 10);
            #2;
            check("bp_i_ready", i_ready, (rel < 5 || rel >= 10));
            c0 = sb.size();
            tick();
            if (sb.size() > c0 || (n < 10 && i_valid && rel != 5 && !(rel > 5 && rel < 10)))
                n = (n < 10) ? n + 1 : n;
        end
        i_valid = 1'b0;
        o_ready = 1'b1;
        check("bp_tag_count", seen.size(), 10);
        for (int k = 0; k < seen.size() && k < 10; k++) check("bp_tag_order", seen[k], k);

        // Async reset with samples in flight
        for (int k = 0; k < 3; k++) begin
            drive(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'b0,
                  8'(8'hA0 + k), 1'b1);
            tick();
        end
        i_valid = 1'b0;
        #3 rst = 1'b0;
        #1;
        check("arst_o_valid", o_valid, 0);
        check("arst_o_data_re", o_data_re, 0);
        check("arst_o_data_im", o_data_im, 0);
        check("arst_o_sat", o_sat, 0);
        check("arst_o_tag", o_tag, 0);
        check("arst_trunc_valid", t_o_valid, 0);
        sb.delete();
        #12 rst = 1'b1;
        tick();
        check("post_rst_i_ready", i_ready, 1);
        c0 = cyc;
        drive(16'sd4096, -16'sd2048, 16'sd1000, 16'sd3, 1'b1, 8'hC3, 1'b1);
        tick();
        i_valid = 1'b0;
        for (int k = 0; k < 8 && !o_valid; k++) tick();
        check("post_rst_latency", cyc - c0, 3);
        check("post_rst_tag", o_tag, 8'hC3);
        tick();

        // Random stream with random backpressure
        for (int k = 0; k < 300; k++) begin
            drive(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                  1'($urandom), 8'($urandom), ($urandom_range(3) != 0));
            o_ready = ($urandom_range(3) != 0);
            tick();
        end
        i_valid = 1'b0;
        o_ready = 1'b1;
        for (int k = 0; k < 10 && sb.size() > 0; k++) tick();
        check("drain_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
